tx_fifo_arbiter: RTL and testbench

- Shares the single write port of the transmit byte FIFO between N requesters; each requester sends whole packets (byte stream terminated by LAST).
- Grant is round-robin at packet granularity, so one requester's packet bytes are never interleaved with another's.
- Applies FIFO back-pressure (FULL) to the current owner.
- A watchdog releases the port if the owner stalls mid-packet.

---
 rtl/tx_fifo_arbiter.sv | 143 ++++++++++++++
 tb/tb_tx_fifo_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: shares the single write port of the transmit byte FIFO between N requesters.
// Ownership is granted round-robin per packet, so one packet's bytes are never interleaved with
// another's. A watchdog drops the owner if it stalls mid-packet for TIMEOUT cycles.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   REQ[N]          per-requester byte valid; DATA/LAST held stable while high
//   DATA[8N]        byte from requester i on DATA[8i+7:8i]
//   LAST[N]         current byte of requester i ends its packet
//   ACK[N]          one-hot: requester i's byte consumed this cycle
//   GNT[N]          one-hot current owner, zero when idle
//   FULL            FIFO full (back-pressure)
//   FIFO_DATA/WE    FIFO write port
//   BUSY            packet in progress
//   ERR, ERR_ID     one-cycle watchdog release pulse and the released requester (ERR_ID holds)
module tx_fifo_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [8*N-1:0]       DATA,
  input  logic [N-1:0]         LAST,
  output logic [N-1:0]         ACK,
  output logic [N-1:0]         GNT,
  input  logic                 FULL,
  output logic [7:0]           FIFO_DATA,
  output logic                 FIFO_WE,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [$clog2(N)-1:0] ERR_ID
);

  localparam int unsigned IW = $clog2(N);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] err_id_q, err_id_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [7:0]    data_arr [N];
  logic [IW-1:0] pick, cand;
  logic          pick_vld;
  logic          burst, own_req, own_last, xfer;
  logic [15:0]   cnt_inc;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = DATA[8*g +: 8];
  end

  assign burst    = (state_q == StBurst);
  assign own_req  = REQ[owner_q];
  assign own_last = LAST[owner_q];
  assign xfer     = burst & own_req & ~FULL;
  assign cnt_inc  = cnt_q + 16'd1;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!pick_vld && REQ[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    GNT       = '0;
    ACK       = '0;
    FIFO_WE   = xfer;
    FIFO_DATA = burst ? data_arr[owner_q] : 8'h00;
    BUSY      = burst;
    ERR       = err_q;
    ERR_ID    = err_id_q;
    if (burst) GNT[owner_q] = 1'b1;
    if (xfer)  ACK[owner_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    err_id_d = err_id_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StBurst;
          owner_d = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      StBurst: begin
        if (xfer) begin
          cnt_d = '0;
          if (own_last) state_d = StIdle;
        end else if (!own_req) begin
          // Back-pressure with REQ held is not a stall; only an absent owner byte counts.
          if (cnt_inc == 16'(TIMEOUT)) begin
            state_d  = StIdle;
            cnt_d    = '0;
            err_d    = 1'b1;
            err_id_d = owner_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      last_q   <= IW'(N - 1);
      cnt_q    <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Testbench for tx_fifo_arbiter: drivers feed per-requester packet queues, a monitor compares
// every cycle against a packet-level reference model and per-requester expected byte queues.
module tb_tx_fifo_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   last;
  logic [N-1:0]   ack;
  logic [N-1:0]   gnt;
  logic           full;
  logic [7:0]     fifo_data;
  logic           fifo_we;
  logic           busy;
  logic           err;
  logic [1:0]     err_id;

  tx_fifo_arbiter #(
    .N       (N),
    .TIMEOUT (TO)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .DATA      (data),
    .LAST      (last),
    .ACK       (ack),
    .GNT       (gnt),
    .FULL      (full),
    .FIFO_DATA (fifo_data),
    .FIFO_WE   (fifo_we),
    .BUSY      (busy),
    .ERR       (err),
    .ERR_ID    (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] drv_q [N][$];  // {last, byte} still to present
  logic [8:0] exp_q [N][$];  // {last, byte} expected at the FIFO
  int         wr_log [$];    // requester index of every observed FIFO write
  int         wr_cnt [N];
  logic [N-1:0] ack_seen;
  logic       in_pkt [N];
  int         rate;
  logic       full_force;
  logic       full_rand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic push(input int id, input logic lst, input logic [7:0] b);
    drv_q[id].push_back({lst, b});
    exp_q[id].push_back({lst, b});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Driver: presents bytes after each rising edge, holds a byte until it is acknowledged.
  initial begin : driver
    req  = '0;
    data = '0;
    last = '0;
    full = 1'b0;
    for (int i = 0; i < N; i++) in_pkt[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          drv_q[i].delete();
          in_pkt[i] = 1'b0;
        end
        req  = '0;
        data = '0;
        last = '0;
        full = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && ack_seen[i]) begin
            in_pkt[i] = !drv_q[i][0][8];
            void'(drv_q[i].pop_front());
            req[i] = 1'b0;
          end
          if (!req[i] && drv_q[i].size() > 0 &&
              (in_pkt[i] || $urandom_range(99) < rate)) begin
            req[i]           = 1'b1;
            data[8*i +: 8]   = drv_q[i][0][7:0];
            last[i]          = drv_q[i][0][8];
          end
        end
        full = full_force || (full_rand && ($urandom_range(99) < 30));
      end
    end
  end

  // Monitor with reference model: ownership per packet, rotation from the previous owner,
  // release after LAST or after TIMEOUT consecutive owner-absent cycles.
  initial begin : monitor
    int m_own, m_last, m_stall, idx, pend_id, w;
    logic pend_err, rel;
    logic [N-1:0] prev_req, exp_g;
    logic exp_we;
    logic [8:0] e;
    m_own = -1; m_last = N - 1; m_stall = 0; pend_err = 0; pend_id = 0; rel = 0;
    prev_req = '0; ack_seen = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_own = -1; m_last = N - 1; m_stall = 0; pend_err = 0; rel = 0;
        prev_req = '0; ack_seen = '0;
      end else begin
        ack_seen = ack;
        if (m_own >= 0) begin
          if (rel || pend_err) m_own = -1;
        end else begin
          idx = rr_pick(prev_req, m_last);
          if (idx >= 0) begin
            m_own = idx; m_last = idx; m_stall = 0;
          end
        end
        check("err_pulse", {31'd0, err}, {31'd0, pend_err});
        if (pend_err) check("err_id", {30'd0, err_id}, pend_id);
        exp_g = '0;
        if (m_own >= 0) exp_g[m_own] = 1'b1;
        check("gnt", {28'd0, gnt}, {28'd0, exp_g});
        check("busy", {31'd0, busy}, {31'd0, (m_own >= 0)});
        exp_we = (m_own >= 0) && req[m_own] && !full;
        check("fifo_we", {31'd0, fifo_we}, {31'd0, exp_we});
        check("ack", {28'd0, ack}, exp_we ? {28'd0, exp_g} : 32'd0);
        if (fifo_we && full) fail_msg("we_while_full");
        if (exp_we) begin
          if (exp_q[m_own].size() == 0) begin
            fail_msg("unexpected_write");
          end else begin
            e = exp_q[m_own].pop_front();
            check("fifo_data", {24'd0, fifo_data}, {24'd0, e[7:0]});
          end
        end
        if (fifo_we) begin
          w = -1;
          for (int i = 0; i < N; i++) if (ack[i]) w = i;
          if (w >= 0) begin
            wr_log.push_back(w);
            wr_cnt[w]++;
          end
        end
        rel = 1'b0;
        pend_err = 1'b0;
        if (m_own >= 0) begin
          if (exp_we) begin
            m_stall = 0;
            rel = last[m_own];
          end else if (!req[m_own]) begin
            m_stall++;
            if (m_stall == TO) begin
              pend_err = 1'b1;
              pend_id  = m_own;
              m_stall  = 0;
            end
          end
        end
        prev_req = req;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    full_force = 1'b0;
    full_rand  = 1'b0;
    rate       = 100;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      wr_cnt[i] = 0;
    end
    wr_log.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      done = (req == '0) && (gnt == '0);
      for (int i = 0; i < N; i++)
        if (drv_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
    end
    if (!done) fail_msg("drain_timeout");
  endtask

  task automatic wait_writes(input int id, input int n);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      seen = (wr_cnt[id] >= n);
    end
    if (!seen) fail_msg("write_wait_timeout");
  endtask

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int total, len;
    logic seen;
    rst = 1'b1;
    rate = 100;
    full_force = 1'b0;
    full_rand = 1'b0;
    do_reset();
    check("reset_gnt", {28'd0, gnt}, 0);
    check("reset_err_id", {30'd0, err_id}, 0);

    // Single-byte packet from requester 0.
    push(0, 1'b1, 8'h41);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = req[0];
    end
    if (!seen) fail_msg("t1_req_timeout");
    check("t1_gnt_c0", {28'd0, gnt}, 0);
    tick();
    check("t1_gnt_c1", {28'd0, gnt}, 1);
    check("t1_we_c1", {31'd0, fifo_we}, 1);
    check("t1_data_c1", {24'd0, fifo_data}, 32'h41);
    check("t1_ack_c1", {28'd0, ack}, 1);
    tick();
    check("t1_gnt_c2", {28'd0, gnt}, 0);
    wait_drain(50);

    // All four requesting 3-byte packets: strict rotation, packets contiguous.
    do_reset();
    for (int i = 0; i <= N; i++)
      for (int b = 0; b < 3; b++) push(i % N, b == 2, 8'((i << 4) | b));
    wait_drain(200);
    check("t2_len", wr_log.size(), 15);
    if (wr_log.size() == 15)
      for (int i = 0; i < 15; i++) check("t2_order", wr_log[i], (i / 3) % N);

    // Back-pressure for 10 cycles mid-packet.
    do_reset();
    for (int b = 0; b < 4; b++) push(2, b == 3, 8'(8'h20 + b));
    wait_writes(2, 1);
    full_force = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t3_we_full", {31'd0, fifo_we}, 0);
      check("t3_ack_full", {28'd0, ack}, 0);
      check("t3_err_full", {31'd0, err}, 0);
    end
    full_force = 1'b0;
    tick();
    check("t3_resume_we", {31'd0, fifo_we}, 1);
    check("t3_resume_data", {24'd0, fifo_data}, 32'h21);
    wait_drain(100);

    // Watchdog: owner 1 abandons its packet after one byte.
    do_reset();
    push(1, 1'b0, 8'h31);
    wait_writes(1, 1);
    push(0, 1'b1, 8'h05);
    for (int c = 0; c < TO; c++) begin
      tick();
      check("t4_no_err", {31'd0, err}, 0);
      check("t4_gnt_hold", {28'd0, gnt}, 2);
    end
    tick();
    check("t4_err", {31'd0, err}, 1);
    check("t4_err_id", {30'd0, err_id}, 1);
    check("t4_gnt_rel", {28'd0, gnt}, 0);
    tick();
    check("t4_gnt_next", {28'd0, gnt}, 1);
    check("t4_err_once", {31'd0, err}, 0);
    check("t4_err_id_hold", {30'd0, err_id}, 1);
    wait_drain(100);

    // Asynchronous reset mid-packet.
    do_reset();
    for (int b = 0; b < 3; b++) push(3, b == 2, 8'(8'h61 + b));
    wait_writes(3, 1);
    @(posedge clk);
    #3;
    check("t5_we_before", {31'd0, fifo_we}, 1);
    rst = 1'b1;
    #1;
    check("t5_gnt_rst", {28'd0, gnt}, 0);
    check("t5_busy_rst", {31'd0, busy}, 0);
    check("t5_we_rst", {31'd0, fifo_we}, 0);
    check("t5_ack_rst", {28'd0, ack}, 0);
    do_reset();
    for (int i = 0; i < N; i++) push(i, 1'b1, 8'(8'h70 + i));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = (gnt != '0);
    end
    check("t5_first_gnt", {28'd0, gnt}, 1);
    wait_drain(100);

    // Alternating single-byte packets from 2 and 1 with previous owner 1, random FULL.
    do_reset();
    push(1, 1'b1, 8'h10);
    wait_drain(50);
    wr_log.delete();
    full_rand = 1'b1;
    push(2, 1'b1, 8'hA0);
    push(1, 1'b1, 8'hB0);
    push(2, 1'b1, 8'hA1);
    push(1, 1'b1, 8'hB1);
    wait_drain(500);
    check("t6_len", wr_log.size(), 4);
    if (wr_log.size() == 4)
      for (int i = 0; i < 4; i++) check("t6_order", wr_log[i], (i % 2 == 0) ? 2 : 1);

    // Random traffic and random back-pressure.
    do_reset();
    rate = 60;
    full_rand = 1'b1;
    total = 0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 12; p++) begin
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) push(i, b == len - 1, 8'($urandom));
        total += len;
      end
    end
    wait_drain(20000);
    check("t7_bytes", wr_log.size(), total);
    full_rand = 1'b0;
    rate = 100;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
